// File: rtl/gmii_tx_framer_if.sv
// Word-level packet bus into the GMII transmit framer.
// The master presents frame words; the framer (slave) returns a combinational ready.
interface gmii_tx_framer_if;
  logic [63:0] pkt_tx_data_i;
  logic [2:0]  pkt_tx_mod_i;
  logic        pkt_tx_sop_i;
  logic        pkt_tx_eop_i;
  logic        pkt_tx_val_i;
  logic        pkt_tx_rdy_o;

  modport master (
    output pkt_tx_data_i, pkt_tx_mod_i, pkt_tx_sop_i, pkt_tx_eop_i, pkt_tx_val_i,
    input  pkt_tx_rdy_o
  );

  modport slave (
    input  pkt_tx_data_i, pkt_tx_mod_i, pkt_tx_sop_i, pkt_tx_eop_i, pkt_tx_val_i,
    output pkt_tx_rdy_o
  );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, byte-serialised data, underrun abort, 12-slot IFG.
// GMII_TX_FCS_APPEND_EN adds min-size padding and an appended Ethernet CRC-32.
module gmii_tx_framer (
  input  logic            tx_clk_i,
  input  logic            rst_tx_clk_n_i,
  input  logic            tx_clk_en_i,
  gmii_tx_framer_if.slave pkt,
  output logic [7:0]      gmii_tx_d_o,
  output logic            gmii_tx_en_o,
  output logic            gmii_tx_er_o,
  output logic            underrun_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_slot,  w_slot_nxt;
  logic [2:0]  r_idx,   w_idx_nxt;
  logic [2:0]  r_last,  w_last_nxt;
  logic        r_eop,   w_eop_nxt;
  logic [63:0] r_word,  w_word_nxt;
  logic [7:0]  r_d,     w_d_nxt;
  logic        r_en,    w_en_nxt;
  logic        r_er,    w_er_nxt;
  logic        r_urun,  w_urun_nxt;
  logic        w_rdy, w_load, w_abort;
  logic [2:0]  w_idx_inc;

  assign w_idx_inc = r_idx + 3'd1;

`ifdef GMII_TX_FCS_APPEND_EN
  logic [15:0] r_cnt;
  logic [31:0] r_crc;
  logic [31:0] w_fcs;
  logic        w_byte_vld;

  assign w_fcs = ~r_crc;
  // every byte emitted in DATA or PAD (but not the error byte) is counted and CRC'd
  assign w_byte_vld = w_en_nxt & ~w_er_nxt &
                      ((w_state_nxt == S_DATA) || (w_state_nxt == S_PAD));

  function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_eop_nxt   = r_eop;
    w_word_nxt  = r_word;
    w_d_nxt     = 8'h00;
    w_en_nxt    = 1'b0;
    w_er_nxt    = 1'b0;
    w_urun_nxt  = 1'b0;
    w_rdy       = 1'b0;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // sop words wait for the SFD slot; stray non-sop words are drained here
        w_rdy = ~pkt.pkt_tx_sop_i;
        if (pkt.pkt_tx_val_i && pkt.pkt_tx_sop_i) begin
          w_state_nxt = S_PREAMBLE;
          w_slot_nxt  = 4'd0;
          w_d_nxt     = 8'h55;
          w_en_nxt    = 1'b1;
        end
      end
      S_PREAMBLE: begin
        w_en_nxt = 1'b1;
        if (r_slot == 4'd6) begin
          w_state_nxt = S_SFD;
          w_d_nxt     = 8'hD5;
        end else begin
          w_slot_nxt = r_slot + 4'd1;
          w_d_nxt    = 8'h55;
        end
      end
      S_SFD: begin
        w_rdy = 1'b1;
        if (pkt.pkt_tx_val_i) w_load  = 1'b1;
        else                  w_abort = 1'b1;
      end
      S_DATA: begin
        if (r_idx != r_last) begin
          w_idx_nxt = w_idx_inc;
          w_d_nxt   = r_word[{w_idx_inc, 3'b000} +: 8];
          w_en_nxt  = 1'b1;
        end else if (!r_eop) begin
          w_rdy = 1'b1;
          if (pkt.pkt_tx_val_i && !pkt.pkt_tx_sop_i) w_load  = 1'b1;
          else                                        w_abort = 1'b1;
        end else begin
`ifdef GMII_TX_FCS_APPEND_EN
          w_en_nxt = 1'b1;
          if (r_cnt < 16'd60) begin
            w_state_nxt = S_PAD;
          end else begin
            w_state_nxt = S_FCS;
            w_slot_nxt  = 4'd0;
            w_d_nxt     = w_fcs[7:0];
          end
`else
          w_state_nxt = S_IFG;
          w_slot_nxt  = 4'd11;
`endif
        end
      end
`ifdef GMII_TX_FCS_APPEND_EN
      S_PAD: begin
        w_en_nxt = 1'b1;
        if (r_cnt >= 16'd60) begin
          w_state_nxt = S_FCS;
          w_slot_nxt  = 4'd0;
          w_d_nxt     = w_fcs[7:0];
        end
      end
      S_FCS: begin
        if (r_slot[1:0] == 2'd3) begin
          w_state_nxt = S_IFG;
          w_slot_nxt  = 4'd11;
        end else begin
          w_slot_nxt = r_slot + 4'd1;
          w_d_nxt    = w_fcs[{r_slot[1:0] + 2'd1, 3'b000} +: 8];
          w_en_nxt   = 1'b1;
        end
      end
`endif
      S_IFG: begin
        if (r_slot == 4'd0) w_state_nxt = S_IDLE;
        else                w_slot_nxt  = r_slot - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = S_DATA;
      w_word_nxt  = pkt.pkt_tx_data_i;
      w_eop_nxt   = pkt.pkt_tx_eop_i;
      // mod-1 wraps 0 to 7, so mod=0 naturally selects all eight bytes
      w_last_nxt  = pkt.pkt_tx_eop_i ? (pkt.pkt_tx_mod_i - 3'd1) : 3'd7;
      w_idx_nxt   = 3'd0;
      w_d_nxt     = pkt.pkt_tx_data_i[7:0];
      w_en_nxt    = 1'b1;
    end

    // error byte occupies the first IFG slot, so 12 idle slots still follow it
    if (w_abort) begin
      w_state_nxt = S_IFG;
      w_slot_nxt  = 4'd12;
      w_d_nxt     = 8'h00;
      w_en_nxt    = 1'b1;
      w_er_nxt    = 1'b1;
      w_urun_nxt  = 1'b1;
    end
  end

  assign pkt.pkt_tx_rdy_o = tx_clk_en_i & rst_tx_clk_n_i & w_rdy;

  always_ff @(posedge tx_clk_i or negedge rst_tx_clk_n_i) begin
    if (!rst_tx_clk_n_i) begin
      r_state <= S_IDLE;
      r_slot  <= 4'd0;
      r_idx   <= 3'd0;
      r_last  <= 3'd0;
      r_eop   <= 1'b0;
      r_word  <= 64'h0;
      r_d     <= 8'h00;
      r_en    <= 1'b0;
      r_er    <= 1'b0;
      r_urun  <= 1'b0;
    end else if (tx_clk_en_i) begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_eop   <= w_eop_nxt;
      r_word  <= w_word_nxt;
      r_d     <= w_d_nxt;
      r_en    <= w_en_nxt;
      r_er    <= w_er_nxt;
      r_urun  <= w_urun_nxt;
    end
  end

`ifdef GMII_TX_FCS_APPEND_EN
  always_ff @(posedge tx_clk_i or negedge rst_tx_clk_n_i) begin
    if (!rst_tx_clk_n_i) begin
      r_cnt <= 16'd0;
      r_crc <= 32'hFFFF_FFFF;
    end else if (tx_clk_en_i) begin
      if (r_state == S_IDLE) begin
        r_cnt <= 16'd0;
        r_crc <= 32'hFFFF_FFFF;
      end else if (w_byte_vld) begin
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        r_crc <= f_crc8(r_crc, w_d_nxt);
      end
    end
  end
`endif

  assign gmii_tx_d_o  = r_d;
  assign gmii_tx_en_o = r_en;
  assign gmii_tx_er_o = r_er;
  assign underrun_o   = r_urun;

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Port tx_clk_i input 1: the only clock; all logic is rising-edge.
REQ-002 Port rst_tx_clk_n_i input 1: asynchronous, active-low reset.
REQ-003 Port tx_clk_en_i input 1: byte strobe; 1 at every edge at 1000M, 1 in every 10th/100th edge at 100M/10M.
REQ-004 Port pkt_tx_data_i input 64: frame word; data[7:0] is sent first, data[63:56] last.
REQ-005 Port pkt_tx_mod_i input 3: valid bytes in the eop word; 0 means 8, n means bytes 0..n-1.
REQ-006 Port pkt_tx_sop_i input 1: first word of the frame.
REQ-007 Port pkt_tx_eop_i input 1: last word of the frame.
REQ-008 Port pkt_tx_val_i input 1: the word inputs are valid.
REQ-009 Port pkt_tx_rdy_o output 1: combinational; the word is consumed at an edge where val=1 and rdy=1.
REQ-010 Port gmii_tx_d_o output 8: registered GMII data.
REQ-011 Port gmii_tx_en_o output 1: registered GMII enable.
REQ-012 Port gmii_tx_er_o output 1: registered GMII error.
REQ-013 Port underrun_o output 1: registered one-cycle pulse per aborted frame.

Function
REQ-014 The state register and all outputs SHALL change only at edges where tx_clk_en_i=1; otherwise they hold and rdy=0.
REQ-015 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS and IFG; each state lasts one or more clock-enabled byte slots.
REQ-016 IDLE, val=1, sop=1: the word is not consumed; next slot is PREAMBLE; 0x55 appears on gmii_tx_d_o with en=1 at the next enabled edge.
REQ-017 IDLE, val=1, sop=0: rdy=1 and the word is discarded; the FSM stays in IDLE.
REQ-018 PREAMBLE SHALL emit seven 0x55 bytes; SFD SHALL then emit one 0xD5 byte, with rdy=1 during the SFD slot to load the sop word.
REQ-019 DATA SHALL emit the loaded word's bytes in order 0..7, or 0..mod-1 when the word is eop.
REQ-020 On the last byte of a non-eop word, rdy=1 and the next word SHALL be loaded for gap-free output.
REQ-021 A word consumed in DATA with sop=1 SHALL be treated as a protocol error and handled as an underrun.
REQ-022 Underrun is val=0 when a word is required in DATA. Response: one byte 0x00 with en=1 and er=1, a pulse on underrun_o, then IFG.
REQ-023 On underrun, later words up to and including eop SHALL be discarded by IDLE's non-sop rule.
REQ-024 After the eop byte, the next state SHALL be FCS, via PAD when the byte count is below 60 (see Configuration).
REQ-025 A 16-bit byte counter SHALL count data bytes and saturate at 0xFFFF; frames have no upper length limit.
REQ-026 PAD SHALL emit 0x00 bytes until the count reaches 60.
REQ-027 FCS SHALL emit four bytes: standard Ethernet CRC-32 over data and pad, complemented, least-significant byte first.
REQ-028 IFG SHALL drive en=0, er=0 and d=0x00 for exactly 12 byte slots, with rdy=0, then return to IDLE.
REQ-029 In IDLE, en=0, er=0 and d=0x00.
REQ-030 A mod value on a non-eop word SHALL be ignored.
REQ-031 A word with sop=1 and eop=1 SHALL be a valid single-word frame.

Reset
REQ-032 Asserting rst_tx_clk_n_i SHALL immediately force state IDLE, d=0x00, en=0, er=0, underrun_o=0 and rdy=0, and clear the counters and CRC.
REQ-033 Reset mid-frame SHALL truncate the frame without an er indication.
REQ-034 After release, the block SHALL accept a sop word at the first enabled edge.

Configuration
REQ-035 Macro GMII_TX_FCS_APPEND_EN defined: PAD and FCS are active per REQ-024 to REQ-027.
REQ-036 Macro GMII_TX_FCS_APPEND_EN undefined: PAD, FCS and the CRC logic are absent; after the eop byte the next state is IDLE via IFG; input frames carry their own FCS.

Verification
REQ-037 1000M, clk_en=1, one 64-byte frame of bytes 0x00..0x3F in 8 words, mod=0: 7x0x55, 0xD5, 64 bytes in order, 4 correct FCS bytes, en high for 76 slots, then 12 idle slots.
REQ-038 One-word frame, sop=eop=1, mod=3 (with FCS append): 3 data bytes, 57x0x00, 4 FCS bytes; the FCS matches a software CRC-32 of those 60 bytes.
REQ-039 Underrun: val dropped after word 2 of a 5-word frame: after 16 data bytes, one byte with er=1, a one-cycle underrun_o pulse, 12 idle slots; the remaining 3 words are discarded with rdy=1.
REQ-040 100M, clk_en one edge in 10: the same output sequence as REQ-037; each byte held exactly 10 clocks; rdy only on enabled edges.
REQ-041 Reset asserted during DATA byte 20: all outputs low asynchronously; after release, a new sop frame starts with correct preamble timing.
REQ-042 Build without the macro: an 8-word frame produces preamble, SFD, exactly 64 bytes, then IFG, with no pad or FCS.
